// File: rtl/pila.sv
// LIFO stack with combinational top-of-stack read, occupancy count and
// sticky overflow/underflow flags. Used for return addresses and data.
module pila #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int PTRW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [PTRW:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTRW:0] SP_MAX = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0] SP_ONE = (PTRW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTRW:0] sp_q, sp_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_en;
  logic [PTRW:0] top_idx;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == SP_MAX);
  assign count   = sp_q;
  assign top_idx = sp_q - SP_ONE;

  // Read reflects the pre-edge state so a return can consume the address
  // in the same cycle that pops it.
  assign dout = empty ? '0 : mem[top_idx[PTRW-1:0]];

  always_comb begin
    sp_d        = sp_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    if (enable) begin
      if (push) begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          wr_en = 1'b1;
          sp_d  = sp_q + SP_ONE;
        end
      end else begin
        if (empty) begin
          underflow_d = 1'b1;
        end else begin
          sp_d = sp_q - SP_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset. While reset is held sp is 0, so any write lands
  // at or above the stack pointer and is never visible before being rewritten.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[sp_q[PTRW-1:0]] <= din;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_pila.sv
// Directed self-checking bench for pila (WIDTH=10, DEPTH=16).
module tb_pila;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       push;
  logic [9:0] din;
  logic [9:0] dout;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int total;
  int bad;

  pila #(.WIDTH(10), .DEPTH(16), .PTRW(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .push(push), .din(din),
    .dout(dout), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic chk_idle_state(input string tag);
    chk({tag, " count"}, int'(count), 0);
    chk({tag, " empty"}, int'(empty), 1);
    chk({tag, " full"}, int'(full), 0);
    chk({tag, " dout"}, int'(dout), 0);
    chk({tag, " ovf"}, int'(overflow), 0);
    chk({tag, " unf"}, int'(underflow), 0);
  endtask

  // One clocked operation; inputs change on the falling edge, results are
  // sampled 1ns after the rising edge.
  task automatic op(input logic en, input logic p, input logic [9:0] d);
    @(negedge clk);
    enable = en;
    push   = p;
    din    = d;
    @(posedge clk);
    #1;
  endtask

  // Pop, checking the combinational top-of-stack before the edge.
  task automatic pop_chk(input string tag, input int exp_dout, input int exp_cnt);
    @(negedge clk);
    enable = 1'b1;
    push   = 1'b0;
    #1;
    chk({tag, " dout"}, int'(dout), exp_dout);
    @(posedge clk);
    #1;
    chk({tag, " count"}, int'(count), exp_cnt);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b0;
    enable = 1'b0;
    push   = 1'b0;
    din    = '0;

    // Reset then idle
    #2;
    chk_idle_state("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 1'b1, 10'h3FF);
      chk_idle_state("idle");
    end

    // LIFO order
    op(1'b1, 1'b1, 10'h005);
    op(1'b1, 1'b1, 10'h1A3);
    op(1'b1, 1'b1, 10'h3FF);
    chk("lifo cnt3", int'(count), 3);
    pop_chk("lifo pop1", 'h3FF, 2);
    pop_chk("lifo pop2", 'h1A3, 1);
    pop_chk("lifo pop3", 'h005, 0);
    chk("lifo empty", int'(empty), 1);

    // Call / return
    op(1'b1, 1'b1, 10'h020);
    chk("call dout", int'(dout), 'h020);
    pop_chk("ret", 'h020, 0);

    // Full boundary
    for (int i = 0; i < 16; i++) begin
      op(1'b1, 1'b1, 10'(i));
    end
    chk("full flag", int'(full), 1);
    chk("full count", int'(count), 16);
    chk("full empty", int'(empty), 0);
    chk("full ovf0", int'(overflow), 0);
    op(1'b1, 1'b1, 10'h2AA);
    chk("ovf count", int'(count), 16);
    chk("ovf dout", int'(dout), 'h00F);
    chk("ovf flag", int'(overflow), 1);
    for (int i = 15; i >= 0; i--) begin
      pop_chk($sformatf("drain%0d", i), i, i);
    end
    chk("drain empty", int'(empty), 1);
    chk("drain ovf sticky", int'(overflow), 1);

    // Underflow
    chk("unf pre", int'(underflow), 0);
    op(1'b1, 1'b0, 10'h000);
    chk("unf count", int'(count), 0);
    chk("unf dout", int'(dout), 0);
    chk("unf flag", int'(underflow), 1);
    op(1'b1, 1'b1, 10'h011);
    chk("unf push cnt", int'(count), 1);
    chk("unf push dout", int'(dout), 'h011);
    chk("unf sticky", int'(underflow), 1);

    // Async reset mid-burst
    for (int i = 0; i < 5; i++) begin
      op(1'b1, 1'b1, 10'(10'h100 + i));
    end
    chk("burst count", int'(count), 6);
    chk("burst dout", int'(dout), 'h104);
    @(negedge clk);
    enable = 1'b1;
    push   = 1'b1;
    din    = 10'h3C3;
    #2;
    reset = 1'b0;
    #1;
    chk_idle_state("arst");
    @(posedge clk);
    #1;
    chk_idle_state("arst edge");
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    chk_idle_state("arst rel");
    op(1'b1, 1'b1, 10'h155);
    chk("post cnt", int'(count), 1);
    chk("post dout", int'(dout), 'h155);
    pop_chk("post pop", 'h155, 0);
    op(1'b0, 1'b0, 10'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pila.md
Name: pila

Overview:
- LIFO stack that consumes the stack-control outputs of the control unit: enable (activarPilaSubR / activarPilaDatos) and push (pushPilaSubR / pushPilaDatos).
- Two instances per CPU:
  - subroutine return-address stack: call pushes PC+1, return pops into the PC mux.
  - data stack: push/pop of register-file values.
- Pop data is combinational from top-of-stack, so return/pop completes in one cycle.
- Adds occupancy and sticky overflow/underflow error flags for debug.

Parameters:
WIDTH, 10, data word width (10 = PC width for the subroutine instance; 8 for the data instance)
DEPTH, 16, number of entries; power of two, >= 2
PTRW, 4, pointer width = log2(DEPTH); count port is PTRW+1 bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
enable  input  1  stack operation this cycle (activarPila*)
push  input  1  when enable=1: 1 = push, 0 = pop; ignored when enable=0
din  input  WIDTH  data to push
dout  output  WIDTH  current top-of-stack (combinational)
empty  output  1  count == 0
full  output  1  count == DEPTH
count  output  PTRW+1  number of valid entries
overflow  output  1  sticky: a push was attempted while full
underflow  output  1  sticky: a pop was attempted while empty

Behaviour:
- Reset:
  - reset=0 forces sp=0, overflow=0 and underflow=0 immediately, independent of clk.
  - Storage array is not reset.
  - After reset: count=0, empty=1, full=0, dout=0.
- State: sp (PTRW+1 bits) equals count. Storage is mem[0..DEPTH-1]. Top entry is mem[sp-1].
- dout is combinational: empty ? 0 : mem[sp-1]. It reflects the state before the current edge, so the control unit reads the return address in the same cycle that pops it.
- Push (enable=1, push=1) at rising edge:
  - not full: mem[sp] <= din; sp <= sp+1. dout shows din from the next cycle.
  - full: no write, sp unchanged, overflow <= 1.
- Pop (enable=1, push=0) at rising edge:
  - not empty: sp <= sp-1. Entry is not cleared.
  - empty: sp unchanged, underflow <= 1.
- enable=0: no state change; push and din are don't-care.
- Only one operation per cycle. There is no simultaneous push+pop; push=1 with enable=1 is always a push.
- Flags: overflow and underflow stay at 1 until reset. No other clear mechanism. A push/pop that sets a flag has no other side effect.
- Width rules:
  - sp arithmetic uses PTRW+1 bits, so count reaches DEPTH without wrap.
  - mem index uses sp[PTRW-1:0].
  - No wrap-around: sp never exceeds DEPTH and never goes below 0.
- Reset mid-operation: if reset asserts in the same cycle as enable, reset wins. No write is committed and sp=0.
- Reset release: the first rising edge with reset=1 is a normal operating edge.
- full and empty derive combinationally from sp. They are never both 1.

Test Plan:
- Reset then idle:
  - Stimulus: reset=0 for 2 cycles, release, enable=0 for 3 cycles.
  - Required: count=0, empty=1, full=0, dout=0, overflow=0, underflow=0 throughout.
- Push/pop LIFO order:
  - Stimulus: push 10'h005, 10'h1A3, 10'h3FF, then 3 pops.
  - Required: dout=3FF, 1A3, 005 in the cycles before each pop edge; count 3->2->1->0; empty=1 at the end.
- Call/return timing:
  - Stimulus: push 10'h020, then one cycle later enable=1, push=0.
  - Required: dout=020 during the pop cycle (combinational); count=0 after the edge.
- Full boundary (DEPTH=16):
  - Stimulus: push values 0..15, then push 10'h2AA.
  - Required: full=1, count=16 after the 16th push; the 17th push leaves count=16 and dout=15, and overflow=1. Pop sequence then returns 15..0.
- Underflow:
  - Stimulus: from empty, issue a pop.
  - Required: count stays 0, dout=0, underflow=1. A subsequent push of 10'h011 works (count=1, dout=011) and underflow remains 1.
- Async reset mid-burst:
  - Stimulus: after 5 pushes, drop reset between clock edges while enable=1, push=1.
  - Required: count=0, empty=1 and flags 0 immediately, before the next edge. No write is committed while reset=0.
